// File: rtl/spio_pkg.sv
// Shared definitions for the serial display I/O blocks.
//   state_t : arbiter FSM state encoding (IDLE/START/WAIT/DONE)
//   P2S_DW  : default parallel-to-serial shifter width
package spio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int P2S_DW = 16;

endpackage

// File: rtl/p2s_share_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req    : request vector
//   rr_ptr : requester with highest priority this round (< N_REQ)
//   pick   : first set request scanning upward from rr_ptr with wrap
//   any    : at least one request set
module rr_pick #(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       rr_ptr,
    output logic [1:0]       pick,
    output logic             any
);

    always_comb begin
        int j;
        pick = 2'd0;
        any  = 1'b0;
        j    = 0;
        // Scan from the farthest offset down so the nearest set bit to
        // rr_ptr is the last one written and therefore wins.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = int'(rr_ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (req[j]) begin
                pick = 2'(j);
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/p2s_share_arbiter.sv
// Shares one parallel-to-serial display shifter among N_REQ requesters.
// Round-robin grant, latches the winner's word, pulses p2s_start, waits for
// p2s_done (or a timeout) and acks the granted requester.
//   clk, rst_n          : clock, async active-low reset
//   req / req_data      : level requests and packed request words
//   ack / ack_err       : one-cycle completion pulse, timeout flag
//   grant_idx / busy    : current/last grant, FSM not idle
//   p2s_start/p2s_data  : shifter start pulse and held word
//   p2s_done            : shifter completion pulse
module p2s_share_arbiter
    import spio_pkg::*;
#(
    parameter int N_REQ    = 2,
    parameter int DW       = P2S_DW,
    parameter int TMO_BITS = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    ack,
    output logic                ack_err,
    output logic [1:0]          grant_idx,
    output logic                busy,
    output logic                p2s_start,
    output logic [DW-1:0]       p2s_data,
    input  logic                p2s_done
);

    state_t              state;
    logic [1:0]          rr_ptr;
    logic [TMO_BITS-1:0] tmo;
    logic [1:0]          pick;
    logic                any;
    logic [N_REQ-1:0]    ack_one;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .pick   (pick),
        .any    (any)
    );

    assign ack_one = {{(N_REQ-1){1'b0}}, 1'b1} << grant_idx;

    // Outputs are registered: each is set on the edge entering the state in
    // which it must be visible, so p2s_start is high exactly during START
    // and ack exactly during DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rr_ptr    <= 2'd0;
            tmo       <= '0;
            ack       <= '0;
            ack_err   <= 1'b0;
            grant_idx <= 2'd0;
            busy      <= 1'b0;
            p2s_start <= 1'b0;
            p2s_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        grant_idx <= pick;
                        p2s_data  <= req_data[int'(pick)*DW +: DW];
                        p2s_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    p2s_start <= 1'b0;
                    tmo       <= '0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    // done takes priority over a coincident timeout
                    if (p2s_done) begin
                        ack     <= ack_one;
                        ack_err <= 1'b0;
                        state   <= ST_DONE;
                    end else if (tmo == '1) begin
                        ack     <= ack_one;
                        ack_err <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                ST_DONE: begin
                    ack     <= '0;
                    ack_err <= 1'b0;
                    busy    <= 1'b0;
                    // just-served requester drops to lowest priority
                    rr_ptr  <= (grant_idx == 2'(N_REQ - 1)) ? 2'd0 : grant_idx + 2'd1;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_p2s_share_arbiter.sv
// Directed bench for p2s_share_arbiter. Main instance uses default timeout;
// a second instance with TMO_BITS=4 covers timeout corners.
module tb_p2s_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = '0, req_t = '0;
    logic [31:0] req_data = '0, req_data_t = '0;
    logic        p2s_done = 1'b0, p2s_done_t = 1'b0;
    logic [1:0]  ack, ack_t, grant_idx, grant_idx_t;
    logic        ack_err, ack_err_t, busy, busy_t, p2s_start, p2s_start_t;
    logic [15:0] p2s_data, p2s_data_t;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    p2s_share_arbiter #(.N_REQ(2), .DW(16), .TMO_BITS(12)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .ack(ack), .ack_err(ack_err), .grant_idx(grant_idx), .busy(busy),
        .p2s_start(p2s_start), .p2s_data(p2s_data), .p2s_done(p2s_done)
    );

    p2s_share_arbiter #(.N_REQ(2), .DW(16), .TMO_BITS(4)) dut_t (
        .clk(clk), .rst_n(rst_n), .req(req_t), .req_data(req_data_t),
        .ack(ack_t), .ack_err(ack_err_t), .grant_idx(grant_idx_t), .busy(busy_t),
        .p2s_start(p2s_start_t), .p2s_data(p2s_data_t), .p2s_done(p2s_done_t)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one edge, then settle past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (p2s_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit          ok;
        int          cnt;
        logic [1:0]  acc;
        logic [15:0] exp_d [2];

        // ---------------- reset state
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_start", p2s_start, 0);
        chk("rst_data", p2s_data, 0);
        chk("rst_ack", {ack, ack_err}, 0);
        chk("rst_gidx", grant_idx, 0);
        rst_n = 1'b1;
        tick();

        // ---------------- single request
        req_data[15:0] = 16'hA55A;
        req = 2'b01;
        tick();
        chk("single_start", p2s_start, 1);
        chk("single_data", p2s_data, 16'hA55A);
        chk("single_gidx", grant_idx, 0);
        tick();
        chk("single_start_1cyc", p2s_start, 0);
        for (int k = 0; k < 19; k++) tick();
        chk("single_no_early_ack", ack, 0);
        p2s_done = 1'b1;
        tick();
        chk("single_ack", ack, 2'b01);
        chk("single_err", ack_err, 0);
        p2s_done = 1'b0;
        req = 2'b00;
        tick();
        chk("single_ack_pulse", ack, 0);
        chk("single_busy_low", busy, 0);

        // ---------------- async reset mid-WAIT
        req_data[31:16] = 16'hC3C3;
        req = 2'b10;
        tick();
        chk("rstw_gidx", grant_idx, 1);
        tick(); tick();
        #3 rst_n = 1'b0;
        #1;
        chk("rstw_busy", busy, 0);
        chk("rstw_data", p2s_data, 0);
        chk("rstw_gidx0", grant_idx, 0);
        chk("rstw_ack", {ack, ack_err, p2s_start}, 0);
        req = 2'b00;
        tick();
        rst_n = 1'b1;
        acc = '0;
        p2s_done = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            acc |= ack;
        end
        p2s_done = 1'b0;
        chk("rstw_no_ack", acc, 0);
        chk("rstw_idle", busy, 0);

        // ---------------- contention, alternating grants, data hold
        exp_d[0] = 16'h1111;
        exp_d[1] = 16'h2222;
        req_data = {exp_d[1], exp_d[0]};
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_start(ok);
            chk("cont_start_seen", ok, 1);
            chk("cont_gidx", grant_idx, k % 2);
            chk("cont_data", p2s_data, exp_d[k % 2]);
            if (k == 0) begin
                tick();
                req_data[15:0] = 16'h5555;  // change while in WAIT
                tick();
                chk("hold_data", p2s_data, 16'h1111);
                exp_d[0] = 16'h5555;
                for (int m = 0; m < 3; m++) tick();
            end else begin
                for (int m = 0; m < 5; m++) tick();
            end
            p2s_done = 1'b1;
            tick();
            p2s_done = 1'b0;
            chk("cont_ack", ack, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("cont_err", ack_err, 0);
        end
        req = 2'b00;
        tick(); tick();

        // ---------------- timeout (TMO_BITS=4)
        // start visible after edge Es; WAIT entered at Es+1; tmo hits 15 at
        // Es+16; timeout ack registered at Es+17 -> 17 ticks after start.
        req_data_t[15:0] = 16'hBEEF;
        req_t = 2'b01;
        tick();
        chk("tmo_start", p2s_start_t, 1);
        cnt = 0;
        while (ack_t == 2'b00 && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("tmo_latency", cnt, 17);
        chk("tmo_ack", ack_t, 2'b01);
        chk("tmo_err", ack_err_t, 1);
        req_t = 2'b00;
        tick();
        chk("tmo_busy_low", busy_t, 0);

        // ---------------- stray done in IDLE
        p2s_done_t = 1'b1;
        tick();
        p2s_done_t = 1'b0;
        chk("stray_idle_ack", ack_t, 0);
        chk("stray_idle_busy", busy_t, 0);

        // ---------------- stray done in START, then done with tmo all-ones
        req_t = 2'b01;
        tick();
        chk("corner_start", p2s_start_t, 1);
        p2s_done_t = 1'b1;          // sampled while in START: ignored
        tick();
        p2s_done_t = 1'b0;
        chk("stray_start_ack", ack_t, 0);
        for (int k = 0; k < 15; k++) tick();   // now Es+16, tmo == 15
        chk("corner_no_ack_yet", ack_t, 0);
        p2s_done_t = 1'b1;
        tick();
        p2s_done_t = 1'b0;
        req_t = 2'b00;
        chk("corner_ack", ack_t, 2'b01);
        chk("corner_err", ack_err_t, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
